// File: rtl/divisor_frecuencia_prog.sv
// divisor_frecuencia_prog: runtime-programmable clock divider.
// Divides clk_Entrada by a divisor loaded at run time, with pulse or square
// output, a count enable, and divisor changes that take effect only at
// period boundaries so the output never glitches.
// Optional build macro: DIV_ONESHOT_EN adds the 'unico' input. When 'unico'
// is high at a wrap, the block emits that tick and then freezes until the
// next load or reset.
module divisor_frecuencia_prog #(
    parameter int unsigned WIDTH       = 26,
    parameter int unsigned DIV_DEFAULT = 50_000_000
) (
    input  logic             clk_Entrada,
    input  logic             rst,
    input  logic             en,
    input  logic             carga,
    input  logic [WIDTH-1:0] div_valor,
    input  logic             modo,
`ifdef DIV_ONESHOT_EN
    input  logic             unico,
`endif
    output logic             clk_Salida,
    output logic             tick,
    output logic             carga_ack,
    output logic [WIDTH-1:0] cuenta
);

    localparam logic [WIDTH-1:0] DIV_INIT = WIDTH'(DIV_DEFAULT);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO      = WIDTH'(2);

    // Divisors below 2 cannot make a meaningful period, so they become 2.
    function automatic logic [WIDTH-1:0] clampDiv(input logic [WIDTH-1:0] v);
        return (v < TWO) ? TWO : v;
    endfunction

    logic [WIDTH-1:0] r_contador;
    logic [WIDTH-1:0] r_dAct;
    logic [WIDTH-1:0] r_pendValor;
    logic             r_pendFlag;
    logic             r_modoAct;
    logic             r_clkSalida;
    logic             r_tick;
    logic             r_cargaAck;
`ifdef DIV_ONESHOT_EN
    logic             r_frozen;
`endif

    logic [WIDTH-1:0] w_divClamp;
    logic             w_wrap;
    logic             w_halfMark;

    // Decode the last count of the period and the square-wave falling point.
    always_comb begin
        w_divClamp = clampDiv(div_valor);
        w_wrap     = (r_contador == (r_dAct - ONE));
        w_halfMark = (r_contador == ((r_dAct >> 1) - ONE));
    end

    // Counter, active divisor, pending load and registered outputs.
    always_ff @(posedge clk_Entrada) begin
        if (rst) begin
            r_contador  <= '0;
            r_dAct      <= DIV_INIT;
            r_pendValor <= DIV_INIT;
            r_pendFlag  <= 1'b0;
            r_modoAct   <= 1'b0;
            r_clkSalida <= 1'b0;
            r_tick      <= 1'b0;
            r_cargaAck  <= 1'b0;
`ifdef DIV_ONESHOT_EN
            r_frozen    <= 1'b0;
`endif
        end
`ifdef DIV_ONESHOT_EN
        else if (r_frozen) begin
            r_tick      <= 1'b0;
            r_contador  <= '0;
            r_clkSalida <= 1'b0;
            r_cargaAck  <= 1'b0;
            if (carga) begin
                r_dAct     <= w_divClamp;
                r_modoAct  <= modo;
                r_pendFlag <= 1'b0;
                r_cargaAck <= 1'b1;
                r_frozen   <= 1'b0;
            end
        end
`endif
        else if (!en) begin
            r_tick     <= 1'b0;
            r_cargaAck <= 1'b0;
            if (carga) begin
                r_dAct      <= w_divClamp;
                r_contador  <= '0;
                r_clkSalida <= 1'b0;
                r_modoAct   <= modo;
                r_pendFlag  <= 1'b0;
                r_cargaAck  <= 1'b1;
            end
        end
        else if (w_wrap) begin
            r_contador  <= '0;
            r_tick      <= 1'b1;
            r_clkSalida <= 1'b1;
            r_modoAct   <= modo;
            if (carga) begin
                r_dAct     <= w_divClamp;
                r_pendFlag <= 1'b0;
                r_cargaAck <= 1'b1;
            end else if (r_pendFlag) begin
                r_dAct     <= r_pendValor;
                r_pendFlag <= 1'b0;
                r_cargaAck <= 1'b1;
            end else begin
                r_cargaAck <= 1'b0;
            end
`ifdef DIV_ONESHOT_EN
            if (unico) begin
                r_frozen <= 1'b1;
            end
`endif
        end
        else begin
            r_contador <= r_contador + ONE;
            r_tick     <= 1'b0;
            r_cargaAck <= 1'b0;
            if (!r_modoAct) begin
                r_clkSalida <= 1'b0;
            end else if (w_halfMark) begin
                r_clkSalida <= 1'b0;
            end
            if (carga) begin
                r_pendValor <= w_divClamp;
                r_pendFlag  <= 1'b1;
            end
        end
    end

    // Drive the ports straight from their registers.
    always_comb begin
        clk_Salida = r_clkSalida;
        tick       = r_tick;
        carga_ack  = r_cargaAck;
        cuenta     = r_contador;
    end

endmodule

// File: tb/tb_divisor_frecuencia_prog.sv
// Testbench for divisor_frecuencia_prog (WIDTH=8, DIV_DEFAULT=5).
// A behavioural model tracks position-in-period, active divisor and pending
// load; the output clock is derived arithmetically from the position.
module tb_divisor_frecuencia_prog;

    localparam int W   = 8;
    localparam int DEF = 5;

    logic         clk_Entrada = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         carga = 1'b0;
    logic [W-1:0] div_valor = '0;
    logic         modo = 1'b0;
`ifdef DIV_ONESHOT_EN
    logic         unico = 1'b0;
`endif
    logic         clk_Salida;
    logic         tick;
    logic         carga_ack;
    logic [W-1:0] cuenta;

    int total = 0;
    int bad   = 0;

    int mCnt, mD, mPendV;
    bit mPendF, mModo, mSeen, mTick, mAck;

    divisor_frecuencia_prog #(.WIDTH(W), .DIV_DEFAULT(DEF)) dut (
        .clk_Entrada (clk_Entrada),
        .rst         (rst),
        .en          (en),
        .carga       (carga),
        .div_valor   (div_valor),
        .modo        (modo),
`ifdef DIV_ONESHOT_EN
        .unico       (unico),
`endif
        .clk_Salida  (clk_Salida),
        .tick        (tick),
        .carga_ack   (carga_ack),
        .cuenta      (cuenta)
    );

    // Free-running input clock.
    always #5 clk_Entrada = ~clk_Entrada;

    function automatic int clampM(int v);
        return (v < 2) ? 2 : v;
    endfunction

    // Output clock: in square mode high for the first floor(D/2) positions,
    // in pulse mode high only at position 0; low until the first wrap.
    function automatic logic [W+2:0] expVec();
        logic c;
        c = mSeen && (mModo ? (mCnt < (mD / 2)) : (mCnt == 0));
        return {c, mTick, mAck, W'(mCnt)};
    endfunction

    // One input clock edge applied to both DUT and model; returns at negedge.
    task automatic step();
        bit wrap;
        @(posedge clk_Entrada);
        if (rst) begin
            mCnt = 0; mD = DEF; mPendF = 0; mModo = 0; mSeen = 0; mTick = 0; mAck = 0;
        end else if (!en) begin
            mTick = 0; mAck = 0;
            if (carga) begin
                mD = clampM(int'(div_valor)); mCnt = 0; mSeen = 0; mAck = 1;
                mModo = modo; mPendF = 0;
            end
        end else begin
            wrap  = (mCnt + 1 == mD);
            mTick = wrap;
            mAck  = 0;
            if (wrap) begin
                mCnt = 0; mSeen = 1; mModo = modo;
                if (carga) begin
                    mD = clampM(int'(div_valor)); mAck = 1; mPendF = 0;
                end else if (mPendF) begin
                    mD = mPendV; mAck = 1; mPendF = 0;
                end
            end else begin
                mCnt++;
                if (carga) begin
                    mPendV = clampM(int'(div_valor)); mPendF = 1;
                end
            end
        end
        @(negedge clk_Entrada);
    endtask

    task automatic doReset();
        rst = 1'b1; en = 1'b0; carga = 1'b0; modo = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        if ({clk_Salida, tick, carga_ack, cuenta} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_outputs got=%h exp=0", {clk_Salida, tick, carga_ack, cuenta});
        end
        total++;
    endtask

    task automatic test_pulse();
        en = 1'b1; modo = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (tick !== ((k % 5) == 0) || clk_Salida !== ((k % 5) == 0) || cuenta !== W'(k % 5)) begin
                bad++;
                $display("[TB] FAIL pulse_cycle k=%0d got tick=%b clk=%b cuenta=%0d exp cuenta=%0d",
                         k, tick, clk_Salida, cuenta, k % 5);
            end
            total++;
        end
    endtask

    task automatic test_square();
        modo = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            step();
            if (k >= 5) begin
                if (clk_Salida !== (((k - 5) % 5) < 2)) begin
                    bad++;
                    $display("[TB] FAIL square_d5 k=%0d got=%b exp=%b", k, clk_Salida, (((k - 5) % 5) < 2));
                end
                total++;
            end
        end
        en = 1'b0; carga = 1'b1; div_valor = W'(2);
        step();
        carga = 1'b0; en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k >= 2) begin
                if (clk_Salida !== ((k % 2) == 0) || {clk_Salida, tick, carga_ack, cuenta} !== expVec()) begin
                    bad++;
                    $display("[TB] FAIL square_d2 k=%0d got=%h exp=%h", k,
                             {clk_Salida, tick, carga_ack, cuenta}, expVec());
                end
                total++;
            end
        end
    endtask

    task automatic test_load_running();
        for (int r = 0; r < 2; r++) begin
            doReset();
            en = 1'b1; modo = 1'b0;
            for (int k = 1; k <= 14; k++) begin
                bit expTick;
                carga     = (k == 2) || (r == 1 && k == 3);
                div_valor = (k == 2) ? W'(3) : W'(7);
                step();
                carga = 1'b0;
                expTick = (r == 0) ? (k == 5 || k == 8 || k == 11 || k == 14) : (k == 5 || k == 12);
                if (tick !== expTick || carga_ack !== (k == 5) ||
                    {clk_Salida, tick, carga_ack, cuenta} !== expVec()) begin
                    bad++;
                    $display("[TB] FAIL load_running r=%0d k=%0d got tick=%b ack=%b exp tick=%b ack=%b",
                             r, k, tick, carga_ack, expTick, (k == 5));
                end
                total++;
            end
        end
    endtask

    task automatic test_idle_clamp();
        en = 1'b0; carga = 1'b1; div_valor = W'(1);
        step();
        carga = 1'b0;
        if (cuenta !== '0 || carga_ack !== 1'b1 || tick !== 1'b0) begin
            bad++;
            $display("[TB] FAIL idle_load got cuenta=%0d ack=%b tick=%b exp 0/1/0", cuenta, carga_ack, tick);
        end
        total++;
        step();
        if (carga_ack !== 1'b0) begin
            bad++;
            $display("[TB] FAIL idle_ack_width got=%b exp=0", carga_ack);
        end
        total++;
        en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (tick !== ((k % 2) == 0)) begin
                bad++;
                $display("[TB] FAIL clamp_period k=%0d got=%b exp=%b", k, tick, ((k % 2) == 0));
            end
            total++;
        end
    endtask

    task automatic test_en_hold();
        doReset();
        en = 1'b1; modo = 1'b0;
        step(); step();
        en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (cuenta !== W'(2) || tick !== 1'b0) begin
                bad++;
                $display("[TB] FAIL en_hold k=%0d got cuenta=%0d tick=%b exp 2/0", k, cuenta, tick);
            end
            total++;
        end
        en = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            if (tick !== (k == 3)) begin
                bad++;
                $display("[TB] FAIL en_resume k=%0d got=%b exp=%b", k, tick, (k == 3));
            end
            total++;
        end
    endtask

    task automatic test_reset_pending();
        doReset();
        en = 1'b1; modo = 1'b0;
        step();
        carga = 1'b1; div_valor = W'(3);
        step();
        carga = 1'b0;
        step();
        rst = 1'b1;
        step();
        if ({clk_Salida, tick, carga_ack, cuenta} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_midperiod got=%h exp=0", {clk_Salida, tick, carga_ack, cuenta});
        end
        total++;
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (tick !== ((k % 5) == 0) || carga_ack !== 1'b0) begin
                bad++;
                $display("[TB] FAIL pending_lost k=%0d got tick=%b ack=%b exp tick=%b ack=0",
                         k, tick, carga_ack, ((k % 5) == 0));
            end
            total++;
        end
    endtask

    task automatic test_random();
        doReset();
        for (int k = 0; k < 1500; k++) begin
            rst       = ($urandom_range(0, 99) == 0);
            en        = ($urandom_range(0, 9) != 0);
            carga     = ($urandom_range(0, 9) == 0);
            div_valor = W'($urandom_range(0, 12));
            if ($urandom_range(0, 9) == 0) modo = ~modo;
            step();
            if ({clk_Salida, tick, carga_ack, cuenta} !== expVec()) begin
                bad++;
                $display("[TB] FAIL random k=%0d got=%h exp=%h", k, {clk_Salida, tick, carga_ack, cuenta}, expVec());
            end
            total++;
        end
        rst = 1'b0; carga = 1'b0;
    endtask

    // Run all scenarios in order and report.
    initial begin
        @(negedge clk_Entrada);
        test_reset();
        test_pulse();
        test_square();
        test_load_running();
        test_idle_clamp();
        test_en_hold();
        test_reset_pending();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
